// File: rtl/inv_mixcol_pkg.sv
// Shared types and constants for the sequential AES InvMixColumns engine.
package inv_mixcol_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Lane coefficient selects for the inverse MixColumns matrix.
    localparam logic [1:0] SEL_0B = 2'b00;
    localparam logic [1:0] SEL_0D = 2'b01;
    localparam logic [1:0] SEL_09 = 2'b10;
    localparam logic [1:0] SEL_0E = 2'b11;

    localparam int unsigned NCOL_DEFAULT = 4;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mult.sv
// Constant GF(2^8) multiplier by one of the InvMixColumns coefficients 0E/0B/0D/09.
module inv_mult
    import inv_mixcol_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [1:0] sel_i,
    output logic [7:0] p_o
);

    logic [7:0] x2, x4, x8;

    assign x2 = xtime(a_i);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    always_comb begin
        p_o = x8 ^ a_i;
        unique case (sel_i)
            SEL_0E: p_o = x8 ^ x4 ^ x2;
            SEL_0B: p_o = x8 ^ x2 ^ a_i;
            SEL_0D: p_o = x8 ^ x4 ^ a_i;
            SEL_09: p_o = x8 ^ a_i;
        endcase
    end

endmodule

// File: rtl/inv_mixcol_seq.sv
// Byte-serial InvMixColumns: one output byte per cycle from four multiplier lanes.
// Define INV_MIXCOL_SEQ_EARLY_ACCEPT_EN to accept a new state in the handshake cycle of DONE.
module inv_mixcol_seq
    import inv_mixcol_pkg::*;
#(
    parameter int unsigned NCOL = NCOL_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NCOL-1:0]  state_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NCOL-1:0]  state_out
);

    localparam int unsigned ColW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(NCOL - 1);

    state_e             st_q, st_d;
    logic [32*NCOL-1:0] in_q, in_d;
    logic [32*NCOL-1:0] res_q, res_d;
    logic [1:0]         row_q, row_d;
    logic [ColW-1:0]    col_q, col_d;
    logic [31:0]        col_word;
    logic [1:0]         lane_sel [4];
    logic [7:0]         lane_out [4];
    logic [7:0]         byte_out;
    logic               accept;

    assign col_word = in_q[32*(NCOL - 32'(col_q)) - 1 -: 32];

    // Lane j always sees a_j; the coefficient rotates with the row being produced.
    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign lane_sel[j] = 2'(j) - row_q - 2'd1;
        inv_mult u_inv_mult (
            .a_i   (col_word[31-8*j -: 8]),
            .sel_i (lane_sel[j]),
            .p_o   (lane_out[j])
        );
    end

    assign byte_out  = lane_out[0] ^ lane_out[1] ^ lane_out[2] ^ lane_out[3];
    assign state_out = res_q;

    always_comb begin
        st_d      = st_q;
        in_d      = in_q;
        res_d     = res_q;
        row_d     = row_q;
        col_d     = col_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        unique case (st_q)
            StIdle: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            StRun: begin
                res_d[32*(NCOL - 32'(col_q)) - 8*32'(row_q) - 1 -: 8] = byte_out;
                if (row_q == 2'd3) begin
                    row_d = 2'd0;
                    if (col_q == ColLast) begin
                        st_d = StDone;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end else begin
                    row_d = row_q + 2'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
`ifdef INV_MIXCOL_SEQ_EARLY_ACCEPT_EN
                in_ready  = out_ready;
                accept    = out_ready & in_valid;
`endif
                if (out_ready) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase

        if (accept) begin
            in_d  = state_in;
            row_d = 2'd0;
            col_d = '0;
            st_d  = StRun;
        end

        // Abort overrides capture and handshake alike.
        if (flush) begin
            st_d  = StIdle;
            in_d  = in_q;
            row_d = 2'd0;
            col_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= StIdle;
            in_q  <= '0;
            res_q <= '0;
            row_q <= 2'd0;
            col_q <= '0;
        end else begin
            st_q  <= st_d;
            in_q  <= in_d;
            res_q <= res_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Scoreboard bench for inv_mixcol_seq: GF(2^8) reference model, directed and random traffic.
module tb_inv_mixcol_seq;

    localparam int NCOL = 4;
    localparam int W    = 32 * NCOL;
    localparam int LAT  = 4 * NCOL;
`ifdef INV_MIXCOL_SEQ_EARLY_ACCEPT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] state_in, state_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] exp;
        int           acc;
    } item_t;
    item_t sb[$];

    inv_mixcol_seq #(.NCOL(NCOL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [W-1:0] invmix(input logic [W-1:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [W-1:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        r = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[W - 1 - 32*c - 8*i -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gmul(a[(row + k) % 4], coef[k]);
                r[W - 1 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: predicts handshake signals from the scoreboard and checks every cycle.
    always @(negedge clk) begin : monitor
        bit in_run, done, exp_rdy;
        if (!rst_n) begin
            sb.delete();
            chk("rst_out_valid", W'(out_valid), '0);
            chk("rst_state_out", state_out, '0);
            chk("rst_in_ready", W'(in_ready), W'(1));
        end else begin
            in_run  = (sb.size() > 0) && (cyc - sb[0].acc < LAT);
            done    = (sb.size() > 0) && !in_run;
            exp_rdy = (sb.size() == 0) ? 1'b1 : (in_run ? 1'b0 : (EARLY & out_ready));
            chk("out_valid", W'(out_valid), W'(done));
            chk("in_ready", W'(in_ready), W'(exp_rdy));
            if (done) chk("state_out", state_out, sb[0].exp);
            if (flush) begin
                sb.delete();
            end else begin
                if (done && out_ready) void'(sb.pop_front());
                if (in_valid && exp_rdy) sb.push_back('{exp: invmix(state_in), acc: cyc + 1});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] s);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_timeout", W'(in_ready), W'(1));
        in_valid = 1'b1;
        state_in = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) chk("valid_timeout", W'(out_valid), W'(1));
    endtask

    task automatic settle();
        int n;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || !in_ready) && n < 100) begin
            step();
            n++;
        end
        step();
    endtask

    localparam logic [W-1:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [W-1:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    initial begin
        logic [W-1:0] kat_exp;
        logic [W-1:0] a_st, b_st;
        int rises, t0, t1, n;

        kat_exp   = KAT_OUT;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Known-answer vector with immediate consumption.
        out_ready = 1'b1;
        send(KAT_IN);
        wait_valid();
        chk("kat", state_out, kat_exp);
        settle();

        // Back-pressure: result must hold for 10 cycles.
        out_ready = 1'b0;
        send(KAT_IN);
        wait_valid();
        repeat (10) step();
        chk("kat_held", state_out, kat_exp);
        out_ready = 1'b1;
        settle();

        // Reset in the middle of RUN.
        send({$urandom, $urandom, $urandom, $urandom});
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), '0);
        chk("mid_rst_data", state_out, '0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (25) step();

        // Flush beats in_valid in IDLE, then flush during RUN.
        flush    = 1'b1;
        in_valid = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_ready", W'(in_ready), W'(1));
        send({$urandom, $urandom, $urandom, $urandom});
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (25) step();

        // Back-to-back states with in_valid and out_ready held high.
        a_st      = {$urandom, $urandom, $urandom, $urandom};
        b_st      = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = a_st;
        step();
        state_in = b_st;
        rises = 0;
        t0 = 0;
        t1 = 0;
        n = 0;
        while (rises < 2 && n < 80) begin
            if (out_valid) begin
                if (rises == 0) t0 = cyc;
                else t1 = cyc;
                rises++;
                if (rises == 2) in_valid = 1'b0;
            end
            if (rises < 2) begin
                step();
                // Skip the remaining DONE cycle so only rising edges are counted.
                if (out_valid && rises == 1 && cyc == t0 + 1) step();
            end
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_rises", W'(rises), W'(2));
        chk("b2b_spacing", W'(t1 - t0), EARLY ? W'(17) : W'(18));
        settle();

        // Noise on in_valid/state_in during RUN must not disturb the captured state.
        out_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 13; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        wait_valid();
        step();
        out_ready = 1'b1;
        settle();

        // Randomized traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 800; i++) begin
            in_valid  = $urandom_range(0, 2) != 0;
            state_in  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 1) == 1;
            flush     = $urandom_range(0, 39) == 0;
            step();
        end
        settle();
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
